paddle_vector_gen: RTL
======================

# paddle_vector_gen

Converts the two end-marker centroids of one tracked paddle into the geometry the game-state stage consumes: paddle center, unit parallel vector and unit normal vector, each vector scaled to length 128 (Q7). One instance per paddle sits between the per-frame marker centroid trackers and the game-state block. It runs once per frame on the `sync` pulse. Normalisation uses a sequential CORDIC with no divider, square root or angle ROM.

## Interface
- `ITER`, 12: number of CORDIC micro-rotations (range 8–15).
- `MIN_LEN`, 8: degenerate threshold in pixels. The marker pair is rejected if max(|dx|,|dy|) < `MIN_LEN`.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `sync`  in  1  one-cycle frame-start pulse; starts a computation
- `ax`, `ay`  in  13 each  end-marker A centroid (col, row), unsigned
- `bx`, `by`  in  13 each  end-marker B centroid (col, row), unsigned
- `a_valid`, `b_valid`  in  1 each  marker detected this frame
- `center_x`, `center_y`  out  13 each  paddle center
- `lx`, `ly`  out  signed 15 each  parallel unit vector, direction A→B, |l|≈128
- `nx`, `ny`  out  signed 15 each  normal, exactly (−ly, lx)
- `vec_valid`  out  1  set by the first successful update; cleared only by reset
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle pulse at end of every started computation
- `vec_updated`  out  1  valid with `done`: 1 if outputs were refreshed, 0 if held

## Operation
- FSM states: IDLE, PREP, ITERATE, COMMIT.
- **IDLE:**
  - `sync`=1 latches ax..by, a_valid and b_valid, then moves to PREP.
  - `sync` is ignored in every other state.
- **PREP:**
  - Compute 14-bit signed dx=bx−ax and dy=by−ay.
  - If either valid bit is 0, or max(|dx|,|dy|) < `MIN_LEN`: set vec_updated=0 and go to COMMIT with a hold flag.
  - Otherwise:
    - Load vectoring pair (vx,vy)=(dx,dy), sign-extended to 16 bits.
    - If dx<0, load (−dx,−dy) instead and set the flip flag.
    - Load rotation pair (rx,ry)=(78·16, 0) = (1248, 0); 78 = round(128·K⁻¹), with 4 fraction bits.
    - Clear the iteration counter i and go to ITERATE.
- **ITERATE**, i = 0..ITER−1, one per cycle:
  - σ = +1 if vy≥0, else −1.
  - vx←vx+σ(vy>>>i), vy←vy−σ(vx>>>i).
  - rx←rx−σ(ry>>>i), ry←ry+σ(rx>>>i).
  - All updates are simultaneous, using old values.
  - After i=ITER−1, go to COMMIT.
- **COMMIT:**
  - Unless the hold flag is set:
    - lx=(rx+8)>>>4 and ly=(ry+8)>>>4, negated if flip is set.
    - nx=−ly, ny=lx.
    - center_x=(ax+bx)>>1 and center_y=(ay+by)>>1, using a 14-bit sum.
    - Set vec_valid=1 and vec_updated=1.
  - All outputs update on the same edge (atomic set).
  - `done`=1 for this one cycle, then go to IDLE.
- Arithmetic: 16-bit signed internal registers, arithmetic right shifts, no saturation needed. Result magnitude is 128±2.
- Reset values:
  - center_x=320, center_y=240.
  - lx=0, ly=128, nx=−128, ny=0.
  - vec_valid=0, busy=0, done=0, vec_updated=0, FSM=IDLE.
- Reset mid-computation aborts, restores all reset values and discards the latched inputs.

## Timing
- `sync` sampled high at edge k:
  - PREP during cycle k+1.
  - ITERATE on edges k+2..k+ITER+1.
  - COMMIT outputs registered at edge k+ITER+2.
  - `done` high in the cycle after that edge.
- Default latency to new outputs is 14 clocks.
- Held or degenerate path: COMMIT at edge k+2, `done` after it, outputs unchanged.
- `busy` is high from edge k+1 through the `done` cycle.
- Outputs are stable between COMMITs, so downstream may sample them at any time.

## Configuration
- `PADDLE_SMOOTH_EN`:
  - Defined: when vec_valid=1 before the COMMIT, the center becomes center_x=(center_x+new_cx)>>1 and center_y likewise. This first-order smoothing reduces tracker jitter. The first update after reset loads the raw value. Vectors are never smoothed.
  - Undefined: the raw center is loaded every update.

## Test plan
1. Reset, then idle 5 cycles:
   - center=(320,240), l=(0,128), n=(−128,0), vec_valid=0, busy=0.
2. A=(100,200), B=(100,300), both valid, sync:
   - 14 clocks later: center=(100,250), l=(0±2,128±2), n=(−ly,lx).
   - done pulses 1 cycle, vec_updated=1, vec_valid=1.
3. A=(300,240), B=(200,240), flip path:
   - l=(−128±2, 0±2), n=(0±2, −128±2), center=(250,240).
4. A=(100,100), B=(200,200):
   - l=(91±2, 91±2), n=(−91±2, 91±2), center=(150,150).
5. b_valid=0, or B=A+(3,2):
   - done 3 cycles after sync with vec_updated=0.
   - All outputs equal their previous values.
6. Three cases:
   - A second sync during ITERATE is ignored: single done, correct result.
   - reset asserted at ITERATE i=5: next cycle busy=0 with reset values and no done pulse.
   - With `PADDLE_SMOOTH_EN`: center 100 then 200 gives 150.

Source files
------------

// File: rtl/paddle_vector_gen.sv
// paddle_vector_gen: marker pair -> paddle center, unit parallel and normal vectors (Q7).
// Optional define PADDLE_SMOOTH_EN averages the new center with the previous one.
module paddle_vector_gen #(
    parameter int ITER    = 12,
    parameter int MIN_LEN = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sync,
    input  logic [12:0]        ax,
    input  logic [12:0]        ay,
    input  logic [12:0]        bx,
    input  logic [12:0]        by,
    input  logic               a_valid,
    input  logic               b_valid,
    output logic [12:0]        center_x,
    output logic [12:0]        center_y,
    output logic signed [14:0] lx,
    output logic signed [14:0] ly,
    output logic signed [14:0] nx,
    output logic signed [14:0] ny,
    output logic               vec_valid,
    output logic               busy,
    output logic               done,
    output logic               vec_updated
);

    typedef enum logic [1:0] {IDLE, PREP, ITERATE, COMMIT} state_t;

    state_t state, state_nx;

    logic [12:0] ax_q, ay_q, bx_q, by_q;
    logic        av_q, bv_q;
    logic        flip, hold;
    logic [3:0]  it;

    logic signed [15:0] vx, vy, rx, ry;
    logic signed [15:0] vxs, vys, rxs, rys;

    logic signed [13:0] dx, dy;
    logic [13:0]        adx, ady;
    logic               degen;

    logic               ld_in, ld_prep, step, commit, last;

    logic [13:0]        sum_x, sum_y;
    logic [12:0]        cx_new, cy_new;
    logic signed [15:0] lx_r, ly_r, lx_n, ly_n;

    assign dx  = signed'({1'b0, bx_q}) - signed'({1'b0, ax_q});
    assign dy  = signed'({1'b0, by_q}) - signed'({1'b0, ay_q});
    assign adx = dx[13] ? 14'(-dx) : 14'(dx);
    assign ady = dy[13] ? 14'(-dy) : 14'(dy);
    assign degen = !av_q || !bv_q ||
                   ((adx < 14'(MIN_LEN)) && (ady < 14'(MIN_LEN)));

    assign last = (it == 4'(ITER - 1));

    assign vxs = vx >>> it;
    assign vys = vy >>> it;
    assign rxs = rx >>> it;
    assign rys = ry >>> it;

    assign sum_x  = {1'b0, ax_q} + {1'b0, bx_q};
    assign sum_y  = {1'b0, ay_q} + {1'b0, by_q};
    assign cx_new = 13'(sum_x >> 1);
    assign cy_new = 13'(sum_y >> 1);

    assign lx_r = (rx + 16'sd8) >>> 4;
    assign ly_r = (ry + 16'sd8) >>> 4;
    assign lx_n = flip ? -lx_r : lx_r;
    assign ly_n = flip ? -ly_r : ly_r;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (sync) state_nx = PREP;
            PREP:    state_nx = degen ? COMMIT : ITERATE;
            ITERATE: if (last) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // per-state control strobes and busy flag
    always_comb begin
        ld_in   = (state == IDLE) && sync;
        ld_prep = (state == PREP);
        step    = (state == ITERATE);
        commit  = (state == COMMIT);
        busy    = (state != IDLE) || done;
    end

    // input latch, CORDIC setup and micro-rotations
    always_ff @(posedge clk) begin
        if (reset) begin
            ax_q <= '0; ay_q <= '0; bx_q <= '0; by_q <= '0;
            av_q <= 1'b0; bv_q <= 1'b0;
            flip <= 1'b0; hold <= 1'b0; it <= '0;
            vx <= '0; vy <= '0; rx <= '0; ry <= '0;
        end else if (ld_in) begin
            ax_q <= ax; ay_q <= ay; bx_q <= bx; by_q <= by;
            av_q <= a_valid; bv_q <= b_valid;
        end else if (ld_prep) begin
            hold <= degen;
            flip <= dx[13];
            it   <= '0;
            vx   <= dx[13] ? -16'(dx) : 16'(dx);
            vy   <= dx[13] ? -16'(dy) : 16'(dy);
            rx   <= 16'sd1248;
            ry   <= 16'sd0;
        end else if (step) begin
            it <= it + 4'd1;
            if (!vy[15]) begin
                vx <= vx + vys; vy <= vy - vxs;
                rx <= rx - rys; ry <= ry + rxs;
            end else begin
                vx <= vx - vys; vy <= vy + vxs;
                rx <= rx + rys; ry <= ry - rxs;
            end
        end
    end

    // atomic output update at COMMIT
    always_ff @(posedge clk) begin
        if (reset) begin
            center_x    <= 13'd320;
            center_y    <= 13'd240;
            lx          <= 15'sd0;
            ly          <= 15'sd128;
            nx          <= -15'sd128;
            ny          <= 15'sd0;
            vec_valid   <= 1'b0;
            done        <= 1'b0;
            vec_updated <= 1'b0;
        end else begin
            done <= commit;
            if (commit) begin
                vec_updated <= !hold;
                if (!hold) begin
                    lx <= 15'(lx_n);
                    ly <= 15'(ly_n);
                    nx <= 15'(-ly_n);
                    ny <= 15'(lx_n);
                    vec_valid <= 1'b1;
`ifdef PADDLE_SMOOTH_EN
                    if (vec_valid) begin
                        center_x <= 13'(({1'b0, center_x} + {1'b0, cx_new}) >> 1);
                        center_y <= 13'(({1'b0, center_y} + {1'b0, cy_new}) >> 1);
                    end else begin
                        center_x <= cx_new;
                        center_y <= cy_new;
                    end
`else
                    center_x <= cx_new;
                    center_y <= cy_new;
`endif
                end
            end
        end
    end

endmodule
